latency_control_unit: RTL and testbench
=======================================

LATENCY_CONTROL_UNIT -- requirements
Module: latency_control_unit

Interface
REQ-001 The module SHALL have parameter MAX_LATENCY, default 32, meaning one more than the largest encodable instruction latency (power of two, >= 2).
REQ-002 The module SHALL have a derived localparam LAT_W = $clog2(MAX_LATENCY), default 5, meaning the latency field width.
REQ-003 The module SHALL have port clock_i  input  1  single clock, all state on rising edge.
REQ-004 The module SHALL have port reset_i  input  1  reset, asynchronous and active-high.
REQ-005 The module SHALL have port flush_i  input  1  synchronous abort of any stall in progress.
REQ-006 The module SHALL have port incoming_latency_i  input  LAT_W  latency of the instruction at the VRR/EXE boundary.
REQ-007 The module SHALL have port halt_pipeline_o  output  1  freeze all inter-stage latches (latch load = ~halt).
REQ-008 The module SHALL have port remaining_o  output  LAT_W  stall cycles still to elapse.

Function
REQ-009 The unit SHALL hold internal counter count_q (LAT_W bits); halt_pipeline_o SHALL equal (count_q != 0), driven directly from the register with no combinational input path.
REQ-010 remaining_o SHALL equal count_q.
REQ-011 Sampling: incoming_latency_i SHALL be evaluated only in cycles where count_q == 0 (pipeline advancing); it SHALL be ignored while halted, because the frozen VRR/EXE latch still holds an unserviced instruction.
REQ-012 Load: when count_q == 0 and incoming_latency_i = L >= 2, count_q SHALL load L-1 at the next edge, so halt asserts the cycle after the instruction enters EXE and lasts exactly L-1 cycles.
REQ-013 L = 0 or L = 1 SHALL cause no stall; count_q stays 0.
REQ-014 Decrement: when count_q != 0, count_q SHALL decrement by 1 each cycle; there is no wrap-around and no underflow below 0.
REQ-015 Back-to-back: the cycle halt deasserts (count_q == 0), the newly presented instruction's latency SHALL be evaluated that same cycle, so the next stall may begin with zero idle gap beyond that one advance cycle.
REQ-016 Maximum: L = MAX_LATENCY-1 SHALL yield MAX_LATENCY-2 halt cycles.
REQ-017 Flush: flush_i = 1 SHALL clear count_q to 0 at the next edge, overriding both load and decrement.

Reset
REQ-018 reset_i high SHALL immediately (asynchronously) clear count_q, halt_pipeline_o = 0 and remaining_o = 0.
REQ-019 Reset asserted mid-stall SHALL abort the stall; after release the first sampled latency SHALL be treated as new.

Configuration
REQ-020 With LCU_STATS_EN defined, the unit SHALL add outputs stall_cycles_o (32 bits, +1 every cycle halt_pipeline_o = 1) and stall_events_o (32 bits, +1 on every load per REQ-012). Both SHALL saturate at all-ones, clear on reset and not clear on flush.
REQ-021 Without LCU_STATS_EN, those ports and their counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-022 A shared package lagarto_v_pkg SHALL hold the MAX_LATENCY default, LAT_W and the latency_t typedef (logic [LAT_W-1:0]).
REQ-023 One sub-module, latency_down_counter (load, decrement, flush, zero flag), SHALL be instantiated.
REQ-024 The companion inter_stage_latch (clock_i, reset, flush_i, load_i, d_i, q_o, parameter WIDTH) SHALL be a separate module and not part of this block.

Verification
REQ-025 The bench SHALL apply reset_i pulse during stall (L=20, after 3 halt cycles) -> halt 0 immediately; remaining_o = 0.
REQ-026 The bench SHALL present L=5 with count 0 -> halt high for exactly 4 consecutive cycles starting next cycle; remaining_o shows 4,3,2,1; then 0.
REQ-027 The bench SHALL present L=0 then L=1 -> halt never asserts; the pipeline advances every cycle.
REQ-028 The bench SHALL present L=3, then keep latency input at 9 while halted -> 2 halt cycles, one advance cycle, then 8 halt cycles; the 9 is not sampled early.
REQ-029 The bench SHALL present L=31 (MAX_LATENCY=32) -> 30 halt cycles. With LCU_STATS_EN, stall_cycles_o = 30 and stall_events_o = 1.
REQ-030 The bench SHALL assert flush_i on the 2nd halt cycle of L=10 -> halt low on the next cycle; the following instruction is evaluated normally.

Source files
------------

// File: rtl/lagarto_v_pkg.sv
// Shared definitions for the latency control unit: default latency range,
// latency field width, the latency type and a saturating increment helper.
package lagarto_v_pkg;

    // One more than the largest encodable instruction latency (power of two)
    localparam int unsigned DEFAULT_MAX_LATENCY = 32;
    localparam int unsigned DEFAULT_LAT_W       = $clog2(DEFAULT_MAX_LATENCY);

    typedef logic [DEFAULT_LAT_W-1:0] latency_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/latency_control_unit_counter.sv
// latency_down_counter: loadable down-counter with synchronous flush and a
// zero flag. Flush beats everything; a non-zero count always decrements, so
// a load is only accepted while the count is already zero.
module latency_down_counter #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // Count register: flush > decrement-while-busy > load-while-idle
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end else if (load_i) begin
            count_q <= load_value_i;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/latency_control_unit.sv
// latency_control_unit: freezes the pipeline for L-1 cycles after an
// instruction of latency L >= 2 enters EXE. The latency input is only
// sampled while the pipeline is advancing.
// Optional build macro LCU_STATS_EN adds saturating stall statistics outputs.
module latency_control_unit
    import lagarto_v_pkg::*;
#(
    parameter int unsigned MAX_LATENCY = DEFAULT_MAX_LATENCY,
    localparam int unsigned LAT_W      = $clog2(MAX_LATENCY)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic [LAT_W-1:0] incoming_latency_i,
    output logic             halt_pipeline_o,
    output logic [LAT_W-1:0] remaining_o
`ifdef LCU_STATS_EN
    ,
    output logic [31:0]      stall_cycles_o,
    output logic [31:0]      stall_events_o
`endif
);

    logic             count_zero;
    logic             load_req;
    logic [LAT_W-1:0] load_value;

    // Latencies 0 and 1 never stall; the counter ignores load while busy
    assign load_req   = count_zero && (incoming_latency_i > LAT_W'(1));
    assign load_value = incoming_latency_i - LAT_W'(1);

    latency_down_counter #(
        .WIDTH (LAT_W)
    ) u_counter (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .load_i       (load_req),
        .load_value_i (load_value),
        .count_o      (remaining_o),
        .zero_o       (count_zero)
    );

    assign halt_pipeline_o = ~count_zero;

`ifdef LCU_STATS_EN
    // Stall statistics: survive flush, cleared only by reset, saturate
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cycles_o <= '0;
            stall_events_o <= '0;
        end else begin
            if (halt_pipeline_o) begin
                stall_cycles_o <= sat_inc32(stall_cycles_o);
            end
            if (load_req && !flush_i) begin
                stall_events_o <= sat_inc32(stall_events_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_latency_control_unit.sv
// Self-checking bench for latency_control_unit (MAX_LATENCY = 32).
// Build with LCU_STATS_EN defined to also check the statistics outputs.
module tb_latency_control_unit;

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       flush_i;
    logic [4:0] incoming_latency_i;
    logic       halt_pipeline_o;
    logic [4:0] remaining_o;
`ifdef LCU_STATS_EN
    logic [31:0] stall_cycles_o;
    logic [31:0] stall_events_o;
`endif

    int checks = 0;
    int errors = 0;

    latency_control_unit #(
        .MAX_LATENCY (32)
    ) dut (
        .clock_i            (clock_i),
        .reset_i            (reset_i),
        .flush_i            (flush_i),
        .incoming_latency_i (incoming_latency_i),
        .halt_pipeline_o    (halt_pipeline_o),
        .remaining_o        (remaining_o)
`ifdef LCU_STATS_EN
        ,
        .stall_cycles_o     (stall_cycles_o),
        .stall_events_o     (stall_events_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic       flush;
        logic [4:0] lat;
        logic       halt;
        logic [4:0] rem;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic add(input logic f, input logic [4:0] l, input logic h, input logic [4:0] r);
        vec_t v;
        v.flush = f; v.lat = l; v.halt = h; v.rem = r;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs, let the edge happen, sample 1 time unit later
    task automatic step(input logic f, input logic [4:0] l);
        flush_i            = f;
        incoming_latency_i = l;
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        int halt_count;

        // L=5: halt for 4 cycles, remaining 4,3,2,1 then 0; value 7 while halted ignored
        add(0, 5, 1, 4);
        add(0, 7, 1, 3);
        add(0, 0, 1, 2);
        add(0, 0, 1, 1);
        add(0, 0, 0, 0);
        // L=0 then L=1: never stalls
        add(0, 0, 0, 0);
        add(0, 1, 0, 0);
        add(0, 0, 0, 0);
        // L=3 then 9 held: 2 halts, one advance, then 8 halts
        add(0, 3, 1, 2);
        add(0, 9, 1, 1);
        add(0, 9, 0, 0);
        add(0, 9, 1, 8);
        add(0, 0, 1, 7);
        add(0, 0, 1, 6);
        add(0, 0, 1, 5);
        add(0, 0, 1, 4);
        add(0, 0, 1, 3);
        add(0, 0, 1, 2);
        add(0, 0, 1, 1);
        add(0, 0, 0, 0);
        // L=10, flush on the 2nd halt cycle, then a normal L=2
        add(0, 10, 1, 9);
        add(0, 0, 1, 8);
        add(1, 0, 0, 0);
        add(0, 2, 1, 1);
        add(0, 0, 0, 0);
        // Flush overrides a load presented while idle
        add(1, 6, 0, 0);
        add(0, 0, 0, 0);

        reset_i            = 1'b1;
        flush_i            = 1'b0;
        incoming_latency_i = 5'd0;
        repeat (2) @(posedge clock_i);
        #1;
        check("reset_halt", 32'(halt_pipeline_o), 32'd0);
        check("reset_rem", 32'(remaining_o), 32'd0);
        reset_i = 1'b0;
        @(negedge clock_i);

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            step(vecs[i].flush, vecs[i].lat);
            check($sformatf("vec%0d_halt", i), 32'(halt_pipeline_o), 32'(vecs[i].halt));
            check($sformatf("vec%0d_rem", i), 32'(remaining_o), 32'(vecs[i].rem));
        end

        // Reset mid-stall: L=20, after 3 halt cycles pulse reset asynchronously
        step(0, 20);
        check("l20_first_rem", 32'(remaining_o), 32'd19);
        step(0, 0);
        step(0, 0);
        check("l20_third_rem", 32'(remaining_o), 32'd17);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_reset_halt", 32'(halt_pipeline_o), 32'd0);
        check("async_reset_rem", 32'(remaining_o), 32'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        step(0, 4);
        check("post_reset_load_rem", 32'(remaining_o), 32'd3);
        check("post_reset_load_halt", 32'(halt_pipeline_o), 32'd1);

        // Clear state (and statistics) before the maximum-latency case
        reset_i = 1'b1;
        #2;
        reset_i = 1'b0;
        @(negedge clock_i);

        // L=31: expect exactly 30 halt cycles within a bounded window
        step(0, 31);
        check("l31_first_rem", 32'(remaining_o), 32'd30);
        halt_count = 0;
        for (int unsigned c = 0; c < 40; c++) begin
            if (halt_pipeline_o) halt_count++;
            step(0, 0);
        end
        check("l31_halt_cycles", 32'(halt_count), 32'd30);
        check("l31_end_halt", 32'(halt_pipeline_o), 32'd0);
`ifdef LCU_STATS_EN
        check("stats_cycles", stall_cycles_o, 32'd30);
        check("stats_events", stall_events_o, 32'd1);
        // Flush must not clear the statistics
        step(1, 0);
        check("stats_cycles_flush", stall_cycles_o, 32'd30);
        check("stats_events_flush", stall_events_o, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
